// File: rtl/xalu_ise_ctrl.sv
// rtl/xalu_ise_ctrl.sv - issue/writeback controller for a downstream custom ALU (ISE)
// Optional macro XALU_ISE_CTRL_TIMEOUT_EN: multi-cycle EXEC wait bounded by WAIT_MAX.
module xalu_ise_ctrl #(
    parameter int unsigned WAIT_MAX = 4
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        flush,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_fn,
    input  logic [6:0]  req_imm,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err,
    output logic [4:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    output logic        ise_val,
    input  logic        ise_oval,
    input  logic [31:0] ise_out
);

    if (WAIT_MAX < 1 || WAIT_MAX > 15) begin : g_bad_wait_max
        $error("xalu_ise_ctrl: WAIT_MAX must be in 1..15");
    end

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      state;
    logic [4:0]  fn_q;
    logic [6:0]  imm_q;
    logic [31:0] rs1_q;
    logic [31:0] rs2_q;
    logic [4:0]  rd_q;
    logic [31:0] rsp_data_q;
    logic        rsp_err_q;
    logic        exec_timeout;

`ifdef XALU_ISE_CTRL_TIMEOUT_EN
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_MAX - 1);
    logic [3:0] wait_cnt;
    // Counter stops at WAIT_LAST because reaching it ends EXEC, so it never wraps.
    assign exec_timeout = (wait_cnt == WAIT_LAST);
`else
    assign exec_timeout = 1'b1;
`endif

    always_ff @(posedge ise_clk) begin
        if (ise_rst) begin
            state      <= IDLE;
            fn_q       <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
`ifdef XALU_ISE_CTRL_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
        end else if (flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        fn_q  <= req_fn;
                        imm_q <= req_imm;
                        rs1_q <= req_rs1;
                        rs2_q <= req_rs2;
                        rd_q  <= req_rd;
                        state <= EXEC;
`ifdef XALU_ISE_CTRL_TIMEOUT_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                EXEC: begin
                    if (ise_oval) begin
                        rsp_data_q <= ise_out;
                        rsp_err_q  <= 1'b0;
                        state      <= RESP;
                    end else if (exec_timeout) begin
                        rsp_data_q <= '0;
                        rsp_err_q  <= 1'b1;
                        state      <= RESP;
                    end
`ifdef XALU_ISE_CTRL_TIMEOUT_EN
                    else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
`endif
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign req_ready = (state == IDLE);
    assign ise_val   = (state == EXEC);
    assign rsp_valid = (state == RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rd    = rd_q;
    assign ise_fn    = fn_q;
    assign ise_imm   = imm_q;
    assign ise_in1   = rs1_q;
    assign ise_in2   = rs2_q;

endmodule

// File: doc/xalu_ise_ctrl.md
XALU_ISE_CTRL -- requirements
Module: xalu_ise_ctrl

Interface
REQ-001 The block SHALL have parameter WAIT_MAX, default 4, giving the maximum EXEC cycles to wait for ise_oval (legal range 1..15).
REQ-002 The block SHALL have port ise_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port ise_rst, input, 1; reset is synchronous and active-high.
REQ-004 The block SHALL have port flush, input, 1: synchronous abort of any in-flight transaction.
REQ-005 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1): the core-side issue handshake.
REQ-006 The block SHALL have ports req_fn (input, 5), req_imm (input, 7), req_rs1 (input, 32), req_rs2 (input, 32) and req_rd (input, 5): opcode class, funct7, operands and destination register.
REQ-007 The block SHALL have ports rsp_valid (output, 1) and rsp_ready (input, 1): the writeback handshake.
REQ-008 The block SHALL have ports rsp_data (output, 32), rsp_rd (output, 5) and rsp_err (output, 1): result, destination register, and unsupported/timeout flag.
REQ-009 The block SHALL have ports ise_fn (output, 5), ise_imm (output, 7), ise_in1 (output, 32), ise_in2 (output, 32) and ise_val (output, 1): the downstream ALU request.
REQ-010 The block SHALL have ports ise_oval (input, 1) and ise_out (input, 32): the downstream ALU result valid and data.

Function
REQ-011 The FSM SHALL have three states: IDLE, EXEC and RESP.
REQ-012 req_ready SHALL be 1 in IDLE only; req_valid&&req_ready captures req_fn, req_imm, req_rs1, req_rs2 and req_rd into operand registers; next state EXEC.
REQ-013 ise_fn, ise_imm, ise_in1 and ise_in2 SHALL be driven directly from the operand registers; ise_val SHALL be 1 only in EXEC.
REQ-014 In EXEC, if ise_oval=1, the block SHALL register ise_out into rsp_data, set rsp_err=0 and go to RESP; ise_oval outside EXEC SHALL be ignored.
REQ-015 In EXEC, if ise_oval=0, the wait counter SHALL increment; see REQ-024/025 for termination.
REQ-016 On a timeout, the block SHALL set rsp_data=0 and rsp_err=1 and go to RESP.
REQ-017 In RESP, rsp_valid SHALL be 1; rsp_data, rsp_rd and rsp_err SHALL be stable until rsp_ready=1, after which the next state is IDLE.
REQ-018 Minimum latency SHALL be: accept at edge T, EXEC during T..T+1, rsp_valid high in the cycle after edge T+1; no back-to-back overlap, so throughput is at most 1 instruction per 3 cycles.
REQ-019 The wait counter SHALL be 4 bits wide, cleared on every entry to EXEC, and SHALL never wrap.
REQ-020 flush=1 SHALL force IDLE, drop the transaction and deassert rsp_valid and ise_val next cycle; flush has priority over every handshake event; flush in IDLE with req_valid=1 SHALL NOT accept the request.
REQ-021 rsp_valid SHALL NOT depend combinationally on rsp_ready; req_ready SHALL NOT depend combinationally on req_valid.

Reset
REQ-022 ise_rst=1 at a clock edge SHALL put the FSM in IDLE and clear the operand registers, wait counter, rsp_data, rsp_rd and rsp_err to 0; outputs then read req_ready=1, rsp_valid=0, ise_val=0 and all data outputs 0.
REQ-023 Reset SHALL override flush and all handshakes, including mid-EXEC and mid-RESP; the aborted transaction SHALL produce no response.

Configuration
REQ-024 With macro XALU_ISE_CTRL_TIMEOUT_EN defined, EXEC SHALL wait up to WAIT_MAX cycles; timeout SHALL occur when the counter equals WAIT_MAX-1 and ise_oval=0.
REQ-025 With XALU_ISE_CTRL_TIMEOUT_EN undefined, EXEC SHALL last exactly one cycle; ise_oval=0 in that cycle SHALL cause an immediate timeout response (rsp_err=1), WAIT_MAX SHALL be ignored, and no counter logic SHALL be present.

Verification
REQ-026 Downstream stub responds same cycle; issue fn=5'b00001, imm=7'h05, rs1=32'h12345678, rs2=32'h9ABCDEF0, rd=5'd7; stub returns 32'hCAFEF00D -> rsp_valid in the 2nd cycle after accept with rsp_data=32'hCAFEF00D, rsp_rd=7, rsp_err=0.
REQ-027 Unsupported fn=5'b00010, stub never asserts ise_oval, macro on, WAIT_MAX=4 -> ise_val high exactly 4 cycles, then rsp_valid with rsp_err=1 and rsp_data=0; with macro off -> ise_val high 1 cycle, same response.
REQ-028 rsp_ready held 0 for 5 cycles -> rsp_valid, rsp_data and rsp_rd constant throughout and req_ready=0; response completes on the first rsp_ready=1 cycle; req_ready=1 in the following cycle.
REQ-029 flush asserted in EXEC (stub delay 3, macro on) -> IDLE next cycle, no rsp_valid pulse; a new request 1 cycle later completes normally with correct data.
REQ-030 ise_rst asserted while in RESP with rsp_ready=0 -> next cycle rsp_valid=0, req_ready=1, rsp_data=0; a late ise_oval pulse in IDLE produces no response.
